// File: rtl/rom_load_sequencer.sv
// -----------------------------------------------------------------------------
// rom_load_sequencer
//
// Purpose:
//   Sequences the HPS ioctl ROM download into the game core. The linear byte
//   stream from hps_io is decoded into four ROM regions and the write port
//   toward the core ROMs is registered (latency 1). The core is held in reset
//   while a download is in progress and for RST_HOLD+1 cycles after it ends.
//   Each download is graded as complete/in-range (load_ok) or overrun/short
//   (load_err). Both flags are sticky until the next download starts.
//
// Optional feature macro:
//   ROM_CKSUM_EN - when defined, cksum accumulates the 16-bit additive sum of
//                  every accepted byte. When undefined, cksum is tied to zero.
//
// Ports:
//   clk_sys         in   1       system clock
//   RESET           in   1       synchronous active-high reset
//   ioctl_download  in   1       download in progress (level)
//   ioctl_wr        in   1       byte strobe, one-cycle pulse
//   ioctl_addr      in   25      linear byte address within the image
//   ioctl_dout      in   8       image byte
//   rom_we          out  1       registered write pulse to the core ROMs
//   rom_sel         out  4       one-hot region select, valid with rom_we
//   rom_addr        out  ADDR_W  region-local byte offset, valid with rom_we
//   rom_dout        out  8       data byte, valid with rom_we
//   core_rst        out  1       reset to the game core
//   load_ok         out  1       last download complete and in range (sticky)
//   load_err        out  1       last download overran or was short (sticky)
//   cksum           out  16      additive checksum of the written bytes
// -----------------------------------------------------------------------------
module rom_load_sequencer #(
   parameter int ADDR_W   = 16,
   parameter int R0_END   = 'h08000,
   parameter int R1_END   = 'h0C000,
   parameter int R2_END   = 'h0E000,
   parameter int R3_END   = 'h10000,
   parameter int RST_HOLD = 255
) (
   input  logic              clk_sys,
   input  logic              RESET,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              rom_we,
   output logic [3:0]        rom_sel,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [7:0]        rom_dout,
   output logic              core_rst,
   output logic              load_ok,
   output logic              load_err,
   output logic [15:0]       cksum
);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   localparam logic [24:0] R0_A      = 25'(R0_END);
   localparam logic [24:0] R1_A      = 25'(R1_END);
   localparam logic [24:0] R2_A      = 25'(R2_END);
   localparam logic [24:0] R3_A      = 25'(R3_END);
   localparam logic [16:0] IMG_SIZE  = 17'(R3_END);
   localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD);
   localparam logic [16:0] CNT_MAX   = 17'h1FFFF;

   state_t            state_q;
   logic              dl_q;
   logic [15:0]       hold_q;
   logic [16:0]       count_q;
   logic              ovf_q;
   logic              rom_we_q;
   logic [3:0]        rom_sel_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [7:0]        rom_dout_q;
   logic              core_rst_q;
   logic              load_ok_q;
   logic              load_err_q;

   logic              dl_rise_d;
   logic              dl_fall_d;
   logic              load_entry_d;
   logic              in_range_d;
   logic [3:0]        sel_d;
   logic [24:0]       base_d;
   logic [ADDR_W-1:0] rom_addr_d;
   logic              accept_d;
   logic [16:0]       count_d;
   logic              ovf_d;
   logic              ok_d;

   // Download edge detection against the registered download level.
   always_comb begin
      dl_rise_d    = ioctl_download & ~dl_q;
      dl_fall_d    = ~ioctl_download & dl_q;
      load_entry_d = dl_rise_d & (state_q != ST_LOAD);
   end

   // Region decode of the incoming linear address.
   always_comb begin
      in_range_d = 1'b1;
      sel_d      = 4'b0000;
      base_d     = 25'd0;
      if (ioctl_addr < R0_A) begin
         sel_d  = 4'b0001;
         base_d = 25'd0;
      end else if (ioctl_addr < R1_A) begin
         sel_d  = 4'b0010;
         base_d = R0_A;
      end else if (ioctl_addr < R2_A) begin
         sel_d  = 4'b0100;
         base_d = R1_A;
      end else if (ioctl_addr < R3_A) begin
         sel_d  = 4'b1000;
         base_d = R2_A;
      end else begin
         in_range_d = 1'b0;
         sel_d      = 4'b0000;
         base_d     = 25'd0;
      end
   end

   // Write acceptance, saturating byte count and completion grading.
   // The grade includes a write that lands on the same cycle download falls.
   always_comb begin
      rom_addr_d = ADDR_W'(ioctl_addr - base_d);
      accept_d   = (state_q == ST_LOAD) & ioctl_wr & in_range_d;
      count_d    = count_q;
      if (accept_d && (count_q != CNT_MAX)) begin
         count_d = count_q + 17'd1;
      end else begin
         count_d = count_q;
      end
      ovf_d = ovf_q | ((state_q == ST_LOAD) & ioctl_wr & ~in_range_d);
      ok_d  = (count_d == IMG_SIZE) & ~ovf_d;
   end

   // Main sequencer: state, hold counter, write port and status flags.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         state_q    <= ST_HOLD;
         // Sample the live level so a download already high at reset release
         // is not mistaken for a new rising edge.
         dl_q       <= ioctl_download;
         hold_q     <= HOLD_INIT;
         count_q    <= 17'd0;
         ovf_q      <= 1'b0;
         rom_we_q   <= 1'b0;
         rom_sel_q  <= 4'b0000;
         rom_addr_q <= '0;
         rom_dout_q <= 8'h00;
         core_rst_q <= 1'b1;
         load_ok_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         dl_q     <= ioctl_download;
         rom_we_q <= accept_d;
         if (accept_d) begin
            rom_sel_q  <= sel_d;
            rom_addr_q <= rom_addr_d;
            rom_dout_q <= ioctl_dout;
         end

         case (state_q)
            ST_HOLD: begin
               core_rst_q <= 1'b1;
               if (dl_rise_d) begin
                  state_q    <= ST_LOAD;
                  count_q    <= 17'd0;
                  ovf_q      <= 1'b0;
                  load_ok_q  <= 1'b0;
                  load_err_q <= 1'b0;
               end else if (hold_q == 16'd0) begin
                  state_q    <= ST_RUN;
                  core_rst_q <= 1'b0;
               end else begin
                  hold_q <= hold_q - 16'd1;
               end
            end
            ST_RUN: begin
               if (dl_rise_d) begin
                  state_q    <= ST_LOAD;
                  core_rst_q <= 1'b1;
                  count_q    <= 17'd0;
                  ovf_q      <= 1'b0;
                  load_ok_q  <= 1'b0;
                  load_err_q <= 1'b0;
               end else begin
                  core_rst_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               core_rst_q <= 1'b1;
               count_q    <= count_d;
               ovf_q      <= ovf_d;
               if (dl_fall_d) begin
                  state_q    <= ST_HOLD;
                  hold_q     <= HOLD_INIT;
                  load_ok_q  <= ok_d;
                  load_err_q <= ~ok_d;
               end else begin
                  state_q <= ST_LOAD;
               end
            end
            default: begin
               state_q    <= ST_HOLD;
               hold_q     <= HOLD_INIT;
               core_rst_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef ROM_CKSUM_EN
   logic [15:0] cksum_q;

   // Additive checksum: cleared on download entry, frozen outside LOAD.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         cksum_q <= 16'h0000;
      end else if (load_entry_d) begin
         cksum_q <= 16'h0000;
      end else if (accept_d) begin
         cksum_q <= cksum_q + {8'h00, ioctl_dout};
      end else begin
         cksum_q <= cksum_q;
      end
   end

   assign cksum = cksum_q;
`else
   assign cksum = 16'h0000;
`endif

   assign rom_we   = rom_we_q;
   assign rom_sel  = rom_sel_q;
   assign rom_addr = rom_addr_q;
   assign rom_dout = rom_dout_q;
   assign core_rst = core_rst_q;
   assign load_ok  = load_ok_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rom_load_sequencer
//
// Self-checking bench for rom_load_sequencer, built with scaled-down region
// boundaries (image of 'h100 bytes) and a short reset hold so full loads stay
// short. A vector table covers the write path and region decode; hand-written
// sequences cover power-up hold, full/overrun/short loads and reset abort.
// -----------------------------------------------------------------------------
module tb_rom_load_sequencer;

   localparam int ADDR_W = 16;
   localparam int R0E    = 'h080;
   localparam int R1E    = 'h0C0;
   localparam int R2E    = 'h0E0;
   localparam int R3E    = 'h100;
   localparam int HOLD   = 10;

   logic              clk_sys = 1'b0;
   logic              RESET;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              rom_we;
   logic [3:0]        rom_sel;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_dout;
   logic              core_rst;
   logic              load_ok;
   logic              load_err;
   logic [15:0]       cksum;

   int checks   = 0;
   int failures = 0;

   rom_load_sequencer #(
      .ADDR_W  (ADDR_W),
      .R0_END  (R0E),
      .R1_END  (R1E),
      .R2_END  (R2E),
      .R3_END  (R3E),
      .RST_HOLD(HOLD)
   ) dut (
      .clk_sys       (clk_sys),
      .RESET         (RESET),
      .ioctl_download(ioctl_download),
      .ioctl_wr      (ioctl_wr),
      .ioctl_addr    (ioctl_addr),
      .ioctl_dout    (ioctl_dout),
      .rom_we        (rom_we),
      .rom_sel       (rom_sel),
      .rom_addr      (rom_addr),
      .rom_dout      (rom_dout),
      .core_rst      (core_rst),
      .load_ok       (load_ok),
      .load_err      (load_err),
      .cksum         (cksum)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic        dl;
      logic        wr;
      logic [24:0] addr;
      logic [7:0]  dout;
      logic        e_we;
      logic [3:0]  e_sel;
      logic [15:0] e_addr;
      logic [7:0]  e_dout;
      logic        e_rst;
      logic        e_ok;
      logic        e_err;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [15:0] exp_ck(input logic [15:0] model);
`ifdef ROM_CKSUM_EN
      return model;
`else
      return 16'h0000;
`endif
   endfunction

   // Count core_rst-high cycles, the current (already high) cycle included.
   task automatic check_hold_release(input string name);
      int cnt;
      cnt = 1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (core_rst) cnt++;
         else break;
      end
      check(name, cnt, HOLD + 1);
      check({name, "_run"}, core_rst, 1'b0);
   endtask

   // Load n bytes (write every cycle) with dout = seed ^ addr[7:0].
   task automatic run_load(input string name, input int n, input logic [7:0] seed);
      logic [15:0] ck;
      int          nwe;
      int          exp_we;
      logic [7:0]  b;
      ck  = 16'h0000;
      nwe = 0;
      ioctl_download = 1'b1;
      ioctl_wr       = 1'b0;
      step();
      check({name, "_entry_rst"}, core_rst, 1'b1);
      check({name, "_entry_ok"}, load_ok, 1'b0);
      check({name, "_entry_err"}, load_err, 1'b0);
      for (int i = 0; i < n; i++) begin
         b          = seed ^ 8'(i);
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(i);
         ioctl_dout = b;
         if (i < R3E) ck = ck + {8'h00, b};
         step();
         if (rom_we) nwe++;
         if (i == R0E - 1) begin
            check({name, "_sel_r0_last"}, rom_sel, 4'b0001);
            check({name, "_addr_r0_last"}, rom_addr, 16'h007F);
         end
         if (i == R0E) begin
            check({name, "_sel_r1_first"}, rom_sel, 4'b0010);
            check({name, "_addr_r1_first"}, rom_addr, 16'h0000);
         end
         if (i >= R3E) check({name, "_no_we_ovf"}, rom_we, 1'b0);
      end
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      step();
      exp_we = (n < R3E) ? n : R3E;
      check({name, "_we_count"}, nwe, exp_we);
      check({name, "_ok"}, load_ok, (n == R3E) ? 1'b1 : 1'b0);
      check({name, "_err"}, load_err, (n == R3E) ? 1'b0 : 1'b1);
      check({name, "_cksum"}, cksum, exp_ck(ck));
      check_hold_release({name, "_hold"});
      check({name, "_ok_sticky"}, load_ok, (n == R3E) ? 1'b1 : 1'b0);
   endtask

   initial begin
      RESET          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = 25'd0;
      ioctl_dout     = 8'h00;

      // Power-up: one reset cycle, no download.
      step();
      RESET = 1'b0;
      check("rst_core_rst", core_rst, 1'b1);
      check("rst_we", rom_we, 1'b0);
      check("rst_sel", rom_sel, 4'b0000);
      check("rst_addr", rom_addr, 16'h0000);
      check("rst_dout", rom_dout, 8'h00);
      check("rst_ok", load_ok, 1'b0);
      check("rst_err", load_err, 1'b0);
      check("rst_cksum", cksum, 16'h0000);
      check_hold_release("pwr_hold");
      check("pwr_ok", load_ok, 1'b0);

      //           dl    wr    addr        dout   we    sel      addr      dout   rst   ok    err
      vecs[0]  = '{1'b1, 1'b0, 25'h000, 8'h00, 1'b0, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 25'h000, 8'h11, 1'b1, 4'b0001, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 25'h07F, 8'h22, 1'b1, 4'b0001, 16'h007F, 8'h22, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 25'h080, 8'h33, 1'b1, 4'b0010, 16'h0000, 8'h33, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 25'h081, 8'h44, 1'b0, 4'b0010, 16'h0000, 8'h33, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 25'h0BF, 8'h55, 1'b1, 4'b0010, 16'h003F, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 25'h0C0, 8'h66, 1'b1, 4'b0100, 16'h0000, 8'h66, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 25'h0DF, 8'h77, 1'b1, 4'b0100, 16'h001F, 8'h77, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 25'h0E0, 8'h88, 1'b1, 4'b1000, 16'h0000, 8'h88, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 25'h0FF, 8'h99, 1'b1, 4'b1000, 16'h001F, 8'h99, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 25'h100, 8'hAA, 1'b0, 4'b1000, 16'h001F, 8'h99, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 25'h0F0, 8'hBB, 1'b1, 4'b1000, 16'h0010, 8'hBB, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 25'h0F1, 8'hCC, 1'b1, 4'b1000, 16'h0011, 8'hCC, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 25'h005, 8'hDD, 1'b0, 4'b1000, 16'h0011, 8'hCC, 1'b1, 1'b0, 1'b1};

      for (int v = 0; v < 14; v++) begin
         ioctl_download = vecs[v].dl;
         ioctl_wr       = vecs[v].wr;
         ioctl_addr     = vecs[v].addr;
         ioctl_dout     = vecs[v].dout;
         step();
         check($sformatf("vec%0d_we", v), rom_we, vecs[v].e_we);
         check($sformatf("vec%0d_sel", v), rom_sel, vecs[v].e_sel);
         check($sformatf("vec%0d_addr", v), rom_addr, vecs[v].e_addr);
         check($sformatf("vec%0d_dout", v), rom_dout, vecs[v].e_dout);
         check($sformatf("vec%0d_rst", v), core_rst, vecs[v].e_rst);
         check($sformatf("vec%0d_ok", v), load_ok, vecs[v].e_ok);
         check($sformatf("vec%0d_err", v), load_err, vecs[v].e_err);
      end
      check("vec_cksum", cksum, exp_ck(16'h0440));
      ioctl_wr = 1'b0;

      // Full image, overrun image and short image.
      run_load("full", R3E, 8'h5A);
      run_load("over", R3E + 4, 8'h00);
      run_load("short", R0E, 8'h01);

      // Reset in the middle of a download.
      ioctl_download = 1'b1;
      ioctl_wr       = 1'b0;
      step();
      for (int i = 0; i < 'h34; i++) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(i);
         ioctl_dout = 8'h3C;
         step();
      end
      RESET      = 1'b1;
      ioctl_addr = 25'h34;
      step();
      RESET = 1'b0;
      check("abort_rst", core_rst, 1'b1);
      check("abort_we", rom_we, 1'b0);
      check("abort_ok", load_ok, 1'b0);
      check("abort_err", load_err, 1'b0);
      check("abort_cksum", cksum, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         ioctl_addr = 25'('h35 + i);
         step();
         check($sformatf("abort_we_%0d", i), rom_we, 1'b0);
         check($sformatf("abort_rst_%0d", i), core_rst, 1'b1);
      end
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      step();
      check("abort_rst_after", core_rst, 1'b1);
      run_load("reload", R3E, 8'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
